// File: rtl/fifo_sync.sv
// Single-clock byte FIFO with enable-gated ports, registered read data and a
// one-cycle valid strobe; full/empty are decoded from the occupancy count.
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [AW-1:0]         wr_ptr_nxt_s;
  logic [AW-1:0]         rd_ptr_nxt_s;
  logic [AW:0]           count_nxt_s;
  logic [DATA_WIDTH-1:0] data_out_nxt_s;
  logic                  valid_nxt_s;

  // Flag decode and port acceptance; full blocks a write even when a read frees a slot.
  always_comb begin
    empty_s  = (count_r == {(AW+1){1'b0}});
    full_s   = (count_r == FULL_CNT);
    wr_acc_s = w_en && !full_s;
    rd_acc_s = r_en && !empty_s;
  end

  // Next-state for pointers, occupancy and the read-data register.
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    count_nxt_s    = count_r;
    data_out_nxt_s = data_out_r;
    valid_nxt_s    = 1'b0;
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_acc_s) begin
      rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
      data_out_nxt_s = mem_r[rd_ptr_r];
      valid_nxt_s    = 1'b1;
    end else begin
      rd_ptr_nxt_s   = rd_ptr_r;
      data_out_nxt_s = data_out_r;
      valid_nxt_s    = 1'b0;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      data_out_r <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      data_out_r <= data_out_nxt_s;
      valid_r    <= valid_nxt_s;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!nrst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  assign data_out = data_out_r;
  assign valid    = valid_r;
  assign empty    = empty_s;
  assign full     = full_s;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_sync;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          nrst;
  logic [DW-1:0] data_in;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          empty;
  logic          full;

  fifo_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .data_out(data_out), .valid(valid), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Reference model: a queue of stored words plus the last read word.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;

  typedef struct {
    logic          rst;
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic          e_empty;
    logic          e_full;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the model at the edge, compare just after it.
  task automatic step(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
    bit wr_ok, rd_ok;
    nrst = rst; w_en = w; r_en = r; data_in = d;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
    end else begin
      rd_ok = r && (model_q.size() > 0);
      wr_ok = w && (model_q.size() < DEPTH);
      if (rd_ok) begin
        exp_dout  = model_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (wr_ok) model_q.push_back(d);
    end
    #1;
    check("valid", 32'(valid), 32'(exp_valid));
    check("data_out", 32'(data_out), 32'(exp_dout));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("full", 32'(full), 32'(model_q.size() == DEPTH));
  endtask

  function automatic vec_t mk(logic rst, logic w, logic r, logic [DW-1:0] d,
                              logic ev, logic [DW-1:0] ed, logic ee, logic ef);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.d = d;
    v.e_valid = ev; v.e_dout = ed; v.e_empty = ee; v.e_full = ef;
    return v;
  endfunction

  initial begin
    nrst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    exp_dout = '0; exp_valid = 1'b0;

    // Directed vector table with hand-derived expectations.
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 8'h00, 1'b0, i == 7));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'(i), i == 7, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h07, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h07, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hAA, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hAA, 1'b1, 1'b0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].e_dout));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
    end

    // Streaming across pointer wrap: occupancy held at 6, words in order.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'(k + 6));
      check("stream_dout", 32'(data_out), 32'(k));
      check("stream_valid", 32'(valid), 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check("stream_count6_empty", 32'(empty), 32'd1);
    check("stream_last_word", 32'(data_out), 32'd25);

    // Simultaneous read+write while full: read taken, write dropped.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    check("full_rw_dout", 32'(data_out), 32'h10);
    check("full_rw_notfull", 32'(full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("full_rw_drain", 32'(data_out), 32'(8'h10 + i));
    end
    check("full_rw_count7", 32'(empty), 32'd1);

    // Mid-operation reset with five stored words.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 1'b1, 8'h99);
    check("midrst_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("midrst_newdata", 32'(data_out), 32'h5A);
    check("midrst_then_empty", 32'(empty), 32'd1);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, first-in-first-out buffer for passing byte-wide data between producer and consumer logic in the same clock domain. Writes and reads are gated by enables and qualified by `full`/`empty` flags. Read data is registered and accompanied by a one-cycle `valid` strobe. Both ports may operate in the same cycle.

## Interface
- `DATA_WIDTH`, default 8: width of `data_in`/`data_out`.
- `DEPTH`, default 8: number of storage entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `nrst`  in  1  reset.
  - One clock; reset is synchronous and active-high.
  - `nrst` = 1 at a rising edge resets the block.
- `data_in`  in  DATA_WIDTH  write data, sampled when a write is accepted.
- `w_en`  in  1  write request.
- `r_en`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid`  out  1  `data_out` holds a newly read word this cycle.
- `empty`  out  1  no stored entries (count == 0).
- `full`  out  1  all entries occupied (count == DEPTH).

## Operation
- State:
  - memory `DEPTH` × `DATA_WIDTH`;
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - occupancy count, log2(DEPTH)+1 bits, range 0..DEPTH.
- Write accepted = `w_en && !full`: `mem[wr_ptr] <= data_in`, `wr_ptr` increments.
- Read accepted = `r_en && !empty`: `data_out <= mem[rd_ptr]`, `rd_ptr` increments, `valid <= 1`.
- No accepted read: `valid <= 0`, `data_out` holds its last value.
- Count update:
  - +1 on write only;
  - −1 on read only;
  - unchanged when both or neither are accepted.
- Flags are decoded combinationally from the count register:
  - `empty` = (count == 0);
  - `full` = (count == DEPTH).
- Simultaneous read and write:
  - 0 < count < DEPTH: both accepted, count unchanged.
  - count == 0: write accepted, read ignored (no fall-through), `valid` = 0.
  - count == DEPTH: read accepted, write dropped (`full` gates the write regardless of `r_en`).
- Overflow and underflow:
  - write while full: silently dropped, no state change from the write;
  - read while empty: ignored, `valid` = 0.
- Data ordering is strictly FIFO across pointer wrap-around.

## Timing
- Reset, at the edge where `nrst` = 1:
  - pointers = 0, count = 0;
  - `data_out` = 0, `valid` = 0;
  - `empty` = 1, `full` = 0.
  - Memory contents are not reset.
  - Reset overrides any concurrent `w_en`/`r_en`.
  - Mid-operation reset discards all stored data.
- Write at edge N:
  - `empty` falls after edge N;
  - a read can first be accepted at edge N+1, with the word on `data_out` and `valid` = 1 after edge N+1.
- Read latency: one cycle, from the edge sampling `r_en` to `data_out`/`valid` updating.
- Sustained `r_en` on a non-empty FIFO yields one word per cycle, with `valid` continuously high.
- The DEPTH-th unmatched write asserts `full` after its edge.
- The last read asserts `empty` after its edge.
  - The final word is on `data_out` with `valid` = 1 in that same following cycle.

## Test plan
- Reset: hold `nrst` = 1 for 2 cycles with `w_en` = `r_en` = 1 -> `empty` = 1, `full` = 0, `valid` = 0, `data_out` = 0.
- Fill: write 0x00..0x07 on 8 consecutive cycles -> `full` = 1 after the 8th edge; a 9th write of 0xFF is dropped and count stays 8.
- Drain: `r_en` = 1 from full until `empty` -> `data_out` = 0x00..0x07 on 8 consecutive cycles with `valid` = 1; `empty` = 1 after the 8th read; `valid` = 0 afterwards; 0xFF never appears.
- Streaming: write 0x00..0x05, then hold `w_en` = `r_en` = 1 with incrementing data -> count stays 6; `data_out` = 0x00, 0x01, … in order with `valid` = 1 every cycle, across pointer wrap.
- Edge cases:
  - `r_en` on an empty FIFO -> `valid` = 0.
  - Simultaneous read+write when empty -> only the write is accepted; count = 1.
  - Simultaneous read+write when full -> read accepted, write dropped; count = 7.
- Mid-operation reset with count = 5 -> count = 0 and `empty` = 1 next cycle; a subsequent write/read returns the new data only.
